// File: rtl/deser_field_pkg.sv
// Shared types for the protobuf field deserializer: wire-type codes,
// the field descriptor supplied by the message walker, and FSM states.
package deser_field_pkg;

  localparam logic [2:0] WIRE_VARINT = 3'd0;
  localparam logic [2:0] WIRE_FIX64  = 3'd1;
  localparam logic [2:0] WIRE_FIX32  = 3'd5;

  // Longest tag accepted: 5 varint bytes cover a 32-bit tag.
  localparam int TAG_MAX = 5;

  typedef struct packed {
    logic [28:0] field_id;
    logic [2:0]  wire_type;
    logic [3:0]  size;
    logic [31:0] offset;
    logic        zigzag;
  } table_entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_TAG,
    S_DEC_TAG,
    S_RD_VAL,
    S_RD_EXT,
    S_DEC_VAL,
    S_WR,
    S_DONE,
    S_ERR
  } deser_state_t;

endpackage

// File: rtl/deser_field_varint_dec.sv
// Combinational protobuf varint decoder. Scans up to MAX_BYTES bytes for
// the first byte with MSB clear; value is the little-endian concatenation
// of the 7-bit groups up to and including that byte, truncated to 64 bits.
module varint_dec #(
  parameter int MAX_BYTES = 10
) (
  input  logic [MAX_BYTES*8-1:0] bytes,
  output logic [63:0]            value,
  output logic [3:0]             len,
  output logic                   term
);

  // Accumulate groups until the terminating byte has been absorbed.
  always_comb begin
    value = '0;
    len   = '0;
    term  = 1'b0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (!term) begin
        value = value | (64'(bytes[i*8 +: 7]) << (7 * i));
        if (!bytes[i*8 + 7]) begin
          term = 1'b1;
          len  = 4'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/deser_field.sv
// Protobuf single-field deserializer: reads tag and payload from the wire
// image over the byte-lane DRAM port, checks the tag against the field
// descriptor, and writes the decoded scalar into the object image.
// Optional build macro: DESER_ZIGZAG_EN (zigzag-decode sint varints).
module deser_field
  import deser_field_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int ADDR_W     = 64,
  parameter int MAX_VARINT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [ADDR_W-1:0]       rd_ptr,
  input  table_entry_t            entry,
  input  logic                    entry_valid,
  output logic                    ready,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_W-1:0]       next_rd_ptr,
  output logic [LANES-1:0]        dram_en,
  output logic                    dram_rdwr,
  output logic [LANES*ADDR_W-1:0] dram_addr,
  output logic [LANES*8-1:0]      dram_data_out,
  input  logic [LANES*8-1:0]      dram_data_in,
  input  logic [LANES-1:0]        dram_valid
);

  // Varint bytes that do not fit in the first full-width read.
  localparam int EXT_N = MAX_VARINT - LANES;
  localparam logic [LANES-1:0] EXT_MASK = LANES'((1 << EXT_N) - 1);

  deser_state_t state;

  logic [ADDR_W-1:0]       base;
  logic [ADDR_W-1:0]       ptr;
  table_entry_t            ent;
  logic [LANES*8-1:0]      tag_buf;
  logic [MAX_VARINT*8-1:0] val_buf;

  logic [63:0] tag_val;
  logic [3:0]  tag_len;
  logic        tag_term;
  logic [63:0] val_val;
  logic [3:0]  val_len;
  logic        val_term;

  logic              acc_done;
  logic              rd_has_term;
  logic              ext_has_term;
  logic              wt_ok;
  logic              size_ok;
  logic [LANES-1:0]  wr_mask;
  logic [3:0]        pay_len;
  logic [63:0]       raw_value;
  logic [63:0]       wr_value;
  logic [ADDR_W-1:0] cons_ptr;

`ifdef DESER_ZIGZAG_EN
  function automatic logic [63:0] zigzag_dec(input logic [63:0] v);
    logic signed [63:0] sign_fill;
    sign_fill = -$signed({63'd0, v[0]});
    return (v >> 1) ^ sign_fill;
  endfunction
`endif

  // Tag decode is limited to TAG_MAX bytes by padding the rest with
  // continuation bytes, so a longer tag reports no terminator.
  varint_dec #(.MAX_BYTES(MAX_VARINT)) u_tag_dec (
    .bytes ({{(MAX_VARINT-TAG_MAX){8'h80}}, tag_buf[TAG_MAX*8-1:0]}),
    .value (tag_val),
    .len   (tag_len),
    .term  (tag_term)
  );

  varint_dec #(.MAX_BYTES(MAX_VARINT)) u_val_dec (
    .bytes (val_buf),
    .value (val_val),
    .len   (val_len),
    .term  (val_term)
  );

  // Access completion and terminator detection on the live read data.
  always_comb begin
    acc_done     = (dram_en != '0) && ((dram_valid & dram_en) == dram_en);
    rd_has_term  = 1'b0;
    ext_has_term = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!dram_data_in[i*8 + 7]) rd_has_term = 1'b1;
    end
    for (int i = 0; i < EXT_N; i++) begin
      if (!dram_data_in[i*8 + 7]) ext_has_term = 1'b1;
    end
  end

  // Payload selection, write mask and consumed-byte pointer.
  always_comb begin
    wt_ok   = (ent.wire_type == WIRE_VARINT) || (ent.wire_type == WIRE_FIX64) ||
              (ent.wire_type == WIRE_FIX32);
    size_ok = (ent.size == 4'd1) || (ent.size == 4'd4) || (ent.size == 4'd8);
    wr_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_mask[i] = (i < int'(ent.size));
    end
    raw_value = val_buf[63:0];
    pay_len   = 4'd8;
    case (ent.wire_type)
      WIRE_VARINT: begin
        raw_value = val_val;
        pay_len   = val_len;
      end
      WIRE_FIX32: begin
        raw_value = {32'h0, val_buf[31:0]};
        pay_len   = 4'd4;
      end
      default: ;
    endcase
    wr_value = raw_value;
`ifdef DESER_ZIGZAG_EN
    if (ent.zigzag && (ent.wire_type == WIRE_VARINT)) wr_value = zigzag_dec(raw_value);
`endif
    cons_ptr = ptr + ADDR_W'(tag_len) + ADDR_W'(pay_len);
  end

  // Request and read-data capture; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && en && entry_valid) begin
      base <= addr;
      ptr  <= rd_ptr;
      ent  <= entry;
    end
    if ((state == S_RD_TAG) && acc_done) tag_buf <= dram_data_in;
    if ((state == S_RD_VAL) && acc_done) val_buf[LANES*8-1:0] <= dram_data_in;
    if ((state == S_RD_EXT) && acc_done) val_buf[MAX_VARINT*8-1:LANES*8] <= dram_data_in[EXT_N*8-1:0];
  end

  // Control FSM with registered DRAM port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ready         <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      dram_en       <= '0;
      dram_rdwr     <= 1'b0;
      dram_addr     <= '0;
      dram_data_out <= '0;
      next_rd_ptr   <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && entry_valid) begin
            ready     <= 1'b0;
            state     <= S_RD_TAG;
            dram_en   <= '1;
            dram_rdwr <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              dram_addr[i*ADDR_W +: ADDR_W] <= rd_ptr + ADDR_W'(i);
            end
          end
        end
        S_RD_TAG: begin
          if (acc_done) begin
            dram_en <= '0;
            state   <= S_DEC_TAG;
          end
        end
        S_DEC_TAG: begin
          if (!tag_term || !wt_ok || (tag_val[2:0] != ent.wire_type) ||
              (tag_val[34:3] != {3'b000, ent.field_id})) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state   <= S_RD_VAL;
            dram_en <= '1;
            for (int i = 0; i < LANES; i++) begin
              dram_addr[i*ADDR_W +: ADDR_W] <= ptr + ADDR_W'(tag_len) + ADDR_W'(i);
            end
          end
        end
        S_RD_VAL: begin
          if (acc_done) begin
            dram_en <= '0;
            if ((ent.wire_type == WIRE_VARINT) && !rd_has_term) state <= S_RD_EXT;
            else state <= S_DEC_VAL;
          end
        end
        S_RD_EXT: begin
          // Issue on entry (enable is low after the previous access), then wait.
          if (dram_en == '0) begin
            dram_en <= EXT_MASK;
            for (int i = 0; i < LANES; i++) begin
              dram_addr[i*ADDR_W +: ADDR_W] <= ptr + ADDR_W'(tag_len) + ADDR_W'(LANES + i);
            end
          end else if (acc_done) begin
            dram_en <= '0;
            if (!ext_has_term) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              state <= S_DEC_VAL;
            end
          end
        end
        S_DEC_VAL: begin
          if (!size_ok || ((ent.wire_type == WIRE_VARINT) && !val_term)) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state     <= S_WR;
            dram_en   <= wr_mask;
            dram_rdwr <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
              dram_addr[i*ADDR_W +: ADDR_W]  <= base + ADDR_W'(ent.offset) + ADDR_W'(i);
              dram_data_out[i*8 +: 8]        <= wr_mask[i] ? wr_value[i*8 +: 8] : 8'h00;
            end
          end
        end
        S_WR: begin
          if (acc_done) begin
            dram_en     <= '0;
            dram_rdwr   <= 1'b0;
            state       <= S_DONE;
            done        <= 1'b1;
            next_rd_ptr <= cons_ptr;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        S_ERR: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Bits intentionally not consumed: high tag bits, unread tag bytes, and
  // the zigzag flag when the feature is compiled out.
  logic unused_ok;
  assign unused_ok = ^{tag_val[63:35], tag_buf[LANES*8-1:TAG_MAX*8], ent.zigzag};

endmodule
